// File: rtl/hilo_muldiv_unit.sv
// HI/LO register file with iterative radix-2 multiply (shift-add) and restoring divide.
// Optional build macro MULDIV_EARLY_OUT_EN: MUL stops once the remaining multiplier bits are all zero.
module hilo_muldiv_unit #(
  parameter int              XLEN           = 32,
  parameter logic [XLEN-1:0] HILO_RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue,
  input  logic [2:0]      hilo_type,
  input  logic [5:0]      funct,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  output logic [XLEN-1:0] rd_data,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic            div_zero
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;   // product accumulator / remainder in low half
  logic [2*XLEN-1:0]   opa_q, opa_d;   // shifting multiplicand / divisor in low half
  logic [XLEN-1:0]     opb_q, opb_d;   // multiplier shift register / dividend-quotient
  logic                neg_q, neg_d, neg_rem_q, neg_rem_d;
  logic                is_div_q, is_div_d, dz_q, dz_d;

  logic            cmd_muldiv, fn_mul, fn_div, fn_signed, accept;
  logic            rs_neg, rt_neg;
  logic [XLEN-1:0] rs_mag, rt_mag, opb_shift;
  logic [XLEN:0]   div_shifted, div_diff;
  logic [2*XLEN-1:0] prod_fixed;

  // Handshake: a command is taken when issue=1 and busy=0 (IDLE or DONE); any
  // non-none command presented while busy sees stall=1, is dropped, and must be held.
  assign busy     = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
  assign stall    = issue && (hilo_type != 3'b000) && busy;
  assign done     = (state_q == S_DONE);
  assign div_zero = (state_q == S_DONE) && dz_q;
  assign accept   = issue && !busy;

  assign rd_data = (hilo_type == 3'b100) ? hi_q :
                   (hilo_type == 3'b010) ? lo_q : '0;

  assign cmd_muldiv = (hilo_type == 3'b111);
  assign fn_mul     = (funct == 6'b011000) || (funct == 6'b011001);
  assign fn_div     = (funct == 6'b011010) || (funct == 6'b011011);
  assign fn_signed  = !funct[0];
  assign rs_neg     = fn_signed && rs_data[XLEN-1];
  assign rt_neg     = fn_signed && rt_data[XLEN-1];
  assign rs_mag     = rs_neg ? -rs_data : rs_data;
  assign rt_mag     = rt_neg ? -rt_data : rt_data;

  assign opb_shift   = opb_q >> 1;
  assign div_shifted = {acc_q[XLEN-1:0], opb_q[XLEN-1]};
  assign div_diff    = div_shifted - {1'b0, opa_q[XLEN-1:0]};
  assign prod_fixed  = neg_q ? -acc_q : acc_q;

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;
    dz_d      = dz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          if (cmd_muldiv && fn_mul) begin
            opa_d    = {{XLEN{1'b0}}, rs_mag};
            opb_d    = rt_mag;
            acc_d    = '0;
            cnt_d    = '0;
            neg_d    = rs_neg ^ rt_neg;
            is_div_d = 1'b0;
            dz_d     = 1'b0;
            state_d  = S_MUL;
          end else if (cmd_muldiv && fn_div) begin
            is_div_d = 1'b1;
            if (rt_data == '0) begin
              dz_d    = 1'b1;
              state_d = S_FIX;
            end else begin
              opa_d     = {{XLEN{1'b0}}, rt_mag};
              opb_d     = rs_mag;
              acc_d     = '0;
              cnt_d     = '0;
              neg_d     = rs_neg ^ rt_neg;
              neg_rem_d = rs_neg;
              dz_d      = 1'b0;
              state_d   = S_DIV;
            end
          end else if (hilo_type == 3'b101) begin
            hi_d = rs_data;
          end else if (hilo_type == 3'b011) begin
            lo_d = rs_data;
          end
        end
      end
      S_MUL: begin
        if (opb_q[0]) acc_d = acc_q + opa_q;
        opa_d = opa_q << 1;
        opb_d = opb_shift;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_FIX;
`ifdef MULDIV_EARLY_OUT_EN
        if (opb_shift == '0) state_d = S_FIX;
`endif
      end
      S_DIV: begin
        // Restoring step: keep the trial difference only when it did not borrow.
        if (!div_diff[XLEN]) begin
          acc_d = {{XLEN{1'b0}}, div_diff[XLEN-1:0]};
          opb_d = {opb_q[XLEN-2:0], 1'b1};
        end else begin
          acc_d = {{XLEN{1'b0}}, div_shifted[XLEN-1:0]};
          opb_d = {opb_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      S_FIX: begin
        if (!dz_q) begin
          if (is_div_q) begin
            lo_d = neg_q ? -opb_q : opb_q;
            hi_d = neg_rem_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
          end else begin
            hi_d = prod_fixed[2*XLEN-1:XLEN];
            lo_d = prod_fixed[XLEN-1:0];
          end
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      hi_q      <= HILO_RESET_VAL;
      lo_q      <= HILO_RESET_VAL;
      cnt_q     <= '0;
      acc_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      is_div_q  <= is_div_d;
      dz_q      <= dz_d;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed scenarios plus randomized
// mult/div/mthi/mtlo traffic checked against a plain-arithmetic reference model.
module tb_hilo_muldiv_unit;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        issue = 1'b0;
  logic [2:0]  hilo_type = 3'b000;
  logic [5:0]  funct = 6'b000000;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic [31:0] rd_data;
  logic        stall, busy, done, div_zero;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_hi, exp_lo;
  logic [63:0] exp_q[$];

  hilo_muldiv_unit #(.XLEN(32), .HILO_RESET_VAL(32'h0)) dut (
    .clk(clk), .reset(reset), .issue(issue), .hilo_type(hilo_type), .funct(funct),
    .rs_data(rs_data), .rt_data(rt_data), .rd_data(rd_data), .stall(stall),
    .busy(busy), .done(done), .div_zero(div_zero)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: returns {div_by_zero, hi, lo}
  function automatic logic [64:0] ref_result(input logic [5:0] fn, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] hi,
                                             input logic [31:0] lo);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     r;
    logic            dz;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    r  = {hi, lo};
    dz = 1'b0;
    case (fn)
      F_MULT:  r = sa * sb;
      F_MULTU: r = ua * ub;
      F_DIV: begin
        if (b == 0) dz = 1'b1;
        else begin
          sq = sa / sb;
          sr = sa % sb;
          r  = {sr[31:0], sq[31:0]};
        end
      end
      F_DIVU: begin
        if (b == 0) dz = 1'b1;
        else begin
          uq = ua / ub;
          ur = ua % ub;
          r  = {ur[31:0], uq[31:0]};
        end
      end
      default: r = {hi, lo};
    endcase
    return {dz, r};
  endfunction

  // Cycles from issue to the done pulse
  function automatic int ref_latency(input logic [5:0] fn, input logic [31:0] b);
    logic [31:0] m;
    int          bl;
    if (fn == F_DIV || fn == F_DIVU) return (b == 0) ? 2 : 34;
    m  = (fn == F_MULT && b[31]) ? -b : b;
    bl = 0;
    for (int i = 0; i < 32; i++) if (m[i]) bl = i + 1;
`ifdef MULDIV_EARLY_OUT_EN
    return ((bl < 1) ? 1 : bl) + 2;
`else
    return (bl >= 0) ? 34 : 34;
`endif
  endfunction

  // Driver tasks
  task automatic write_hilo(input logic to_hi, input logic [31:0] d);
    @(negedge clk);
    issue = 1'b1; hilo_type = to_hi ? 3'b101 : 3'b011; rs_data = d;
    #1 check_eq(to_hi ? "mthi_stall" : "mtlo_stall", stall, 0);
    @(negedge clk);
    issue = 1'b0; hilo_type = 3'b000;
    if (to_hi) exp_hi = d; else exp_lo = d;
  endtask

  task automatic read_check(input string tag);
    @(negedge clk);
    hilo_type = 3'b100;
    #1 check_eq({tag, "_hi"}, rd_data, exp_hi);
    hilo_type = 3'b010;
    #1 check_eq({tag, "_lo"}, rd_data, exp_lo);
    hilo_type = 3'b000;
    #1 check_eq({tag, "_none"}, rd_data, 0);
  endtask

  task automatic run_muldiv(input string tag, input logic [5:0] fn,
                            input logic [31:0] a, input logic [31:0] b);
    logic [64:0] r;
    logic [63:0] got;
    int          lat, k, busy_err;
    r   = ref_result(fn, a, b, exp_hi, exp_lo);
    lat = ref_latency(fn, b);
    exp_q.push_back(r[63:0]);
    @(negedge clk);
    issue = 1'b1; hilo_type = 3'b111; funct = fn; rs_data = a; rt_data = b;
    #1 check_eq({tag, "_issue_stall"}, stall, 0);
    k = 0;
    busy_err = 0;
    do begin
      @(negedge clk);
      issue = 1'b0; hilo_type = 3'b000;
      k++;
      if (!done && !busy) busy_err++;
    end while (!done && k < 60);
    if (!done) check_eq({tag, "_done_timeout"}, 0, 1);
    check_eq({tag, "_latency"}, k, lat);
    check_eq({tag, "_busy_window"}, busy_err, 0);
    check_eq({tag, "_busy_at_done"}, busy, 0);
    check_eq({tag, "_div_zero"}, div_zero, r[64]);
    hilo_type = 3'b100;
    #1 got[63:32] = rd_data;
    hilo_type = 3'b010;
    #1 got[31:0] = rd_data;
    hilo_type = 3'b000;
    check_eq({tag, "_hilo"}, got, exp_q.pop_front());
    exp_hi = r[63:32];
    exp_lo = r[31:0];
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [64:0] r;
    logic [5:0]  fn_tab[4];
    int          errs;
    fn_tab[0] = F_MULT; fn_tab[1] = F_MULTU; fn_tab[2] = F_DIV; fn_tab[3] = F_DIVU;
    exp_hi = 32'h0;
    exp_lo = 32'h0;

    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_div_zero", div_zero, 0);
    read_check("rst");

    run_muldiv("mult_neg1x2", F_MULT, 32'hFFFF_FFFF, 32'h2);
    check_eq("mult_neg1x2_hi_const", {exp_hi, exp_lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    run_muldiv("multu_max_x2", F_MULTU, 32'hFFFF_FFFF, 32'h2);
    run_muldiv("divu_7_2", F_DIVU, 32'd7, 32'd2);
    run_muldiv("div_m7_2", F_DIV, 32'hFFFF_FFF9, 32'd2);
    run_muldiv("div_min_m1", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);

    write_hilo(1'b1, 32'h1234);
    write_hilo(1'b0, 32'h5678);
    run_muldiv("div_by_zero", F_DIV, 32'd5, 32'd0);
    read_check("after_dz");

    run_muldiv("multu_early", F_MULTU, 32'h10, 32'h3);
    run_muldiv("mult_zero", F_MULT, 32'h1234_5678, 32'h0);

    // mthi held against an in-flight multiply
    r = ref_result(F_MULTU, 32'h1234_5679, 32'hFFFF_FFFF, exp_hi, exp_lo);
    @(negedge clk);
    issue = 1'b1; hilo_type = 3'b111; funct = F_MULTU;
    rs_data = 32'h1234_5679; rt_data = 32'hFFFF_FFFF;
    errs = 0;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      issue = 1'b0; hilo_type = 3'b000;
      if (k >= 5) begin
        issue = 1'b1; hilo_type = 3'b101; rs_data = 32'hAAAA;
        #1 if (stall !== (k < 34)) errs++;
      end
    end
    check_eq("stall_window", errs, 0);
    check_eq("stall_done_pulse", done, 1);
    @(negedge clk);
    issue = 1'b0; hilo_type = 3'b000;
    exp_hi = 32'hAAAA;
    exp_lo = r[31:0];
    read_check("held_mthi");

    // Reset in the middle of a multiply
    @(negedge clk);
    issue = 1'b1; hilo_type = 3'b111; funct = F_MULTU;
    rs_data = 32'hDEAD_BEEF; rt_data = 32'hFFFF_FFFF;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      issue = 1'b0; hilo_type = 3'b000;
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_hi = 32'h0;
    exp_lo = 32'h0;
    #1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_done", done, 0);
    hilo_type = 3'b010;
    #1 check_eq("midrst_mflo", rd_data, 0);
    hilo_type = 3'b000;
    run_muldiv("after_rst", F_MULT, 32'hFFFF_FFF0, 32'h0000_0123);

    // hilo_type=111 with a non mul/div funct does nothing
    @(negedge clk);
    issue = 1'b1; hilo_type = 3'b111; funct = 6'b100000;
    rs_data = $urandom; rt_data = $urandom;
    @(negedge clk);
    issue = 1'b0; hilo_type = 3'b000;
    #1 check_eq("nop_busy", busy, 0);
    check_eq("nop_done", done, 0);
    read_check("nop");

    // Randomized traffic
    for (int i = 0; i < 50; i++) begin
      case ($urandom_range(0, 9))
        0: write_hilo(1'b1, $urandom);
        1: write_hilo(1'b0, $urandom);
        default: run_muldiv("rand", fn_tab[$urandom_range(0, 3)], pick_operand(), pick_operand());
      endcase
    end
    read_check("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
